// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues the PC to instruction memory, tracks one
// outstanding request, and buffers returned {pc, instr} pairs for the IF/ID stage.
module if_fetch_ctrl #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     pc_mem_q    [DEPTH];

  logic            in_wait;
  logic            issue;
  logic            accept;
  logic            push;
  logic            pop;
  logic [CW:0]     occ_after_pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    in_wait       = (state_q == S_WAIT);
    pop           = (count_q != '0) && id_ready && !redirect;
    push          = in_wait && imem_rvalid && !redirect;
    // Counting the in-flight request reserves its FIFO slot before issue.
    occ_after_pop = {1'b0, count_q} + {{CW{1'b0}}, in_wait} - {{CW{1'b0}}, pop};
    issue         = Reset_n && !redirect
                    && ((state_q == S_IDLE) || (in_wait && imem_rvalid))
                    && (occ_after_pop < (CW + 1)'(DEPTH));
    accept        = issue && imem_gnt;

    imem_req  = issue;
    imem_addr = Reset_n ? pc : '0;
    pc_en     = Reset_n && (accept || redirect);
  end

  always_comb begin
    state_d  = state_q;
    req_pc_d = accept ? pc : req_pc_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (redirect)         state_d = imem_rvalid ? S_IDLE : S_DROP;
        else if (imem_rvalid) state_d = accept ? S_WAIT : S_IDLE;
      end
      S_DROP: if (imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage is reset because the head entry drives id_instr/id_pc
  // directly, and those must read 0/RESET_PC out of reset.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      instr_mem_q <= '{default: '0};
      pc_mem_q    <= '{default: RESET_PC};
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign id_valid = (count_q != '0);
  assign id_instr = instr_mem_q[rd_ptr_q];
  assign id_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: models the PC register and a hand-driven
// instruction memory whose data word is 0x20000000 | accepted address.
module tb_if_fetch_ctrl;

  localparam logic [31:0] REDIR_TGT = 32'h0000_4000;

  logic        clk;
  logic        Reset_n;
  logic [31:0] pc;
  logic        pc_en;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic [31:0] pend_addr;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .pc          (pc),
    .pc_en       (pc_en),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register and memory address capture.
  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc        <= 32'h0000_3000;
      pend_addr <= '0;
    end else begin
      if (pc_en) pc <= redirect ? REDIR_TGT : pc + 32'd4;
      if (imem_req && imem_gnt) pend_addr <= imem_addr;
    end
  end

  assign imem_rdata = 32'h2000_0000 | pend_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic rdy, input logic rd);
    @(negedge clk);
    imem_gnt    = g;
    imem_rvalid = rv;
    id_ready    = rdy;
    redirect    = rd;
    #1;
  endtask

  task automatic restart();
    @(negedge clk);
    Reset_n     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    #1;
  endtask

  initial begin
    Reset_n     = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    id_ready    = 1'b1;
    redirect    = 1'b0;

    // Reset values, with gnt/ready high to exercise the forcing.
    @(negedge clk); #1;
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'h3000);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_pc_en", {31'b0, pc_en}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);

    // Stream with 1-cycle memory.
    @(negedge clk);
    Reset_n = 1'b1;
    #1;
    check("s_c0_req", {31'b0, imem_req}, 32'd1);
    check("s_c0_addr", imem_addr, 32'h3000);
    check("s_c0_pc_en", {31'b0, pc_en}, 32'd1);
    drive(1, 1, 1, 0);
    check("s_c1_valid", {31'b0, id_valid}, 32'd0);
    check("s_c1_pc_en", {31'b0, pc_en}, 32'd1);
    check("s_c1_addr", imem_addr, 32'h3004);
    drive(1, 1, 1, 0);
    check("s_c2_valid", {31'b0, id_valid}, 32'd1);
    check("s_c2_id_pc", id_pc, 32'h3000);
    check("s_c2_instr", id_instr, 32'h2000_3000);
    check("s_c2_pc_en", {31'b0, pc_en}, 32'd1);
    drive(1, 1, 1, 0);
    check("s_c3_id_pc", id_pc, 32'h3004);
    check("s_c3_pc_en", {31'b0, pc_en}, 32'd1);
    drive(1, 1, 1, 0);
    check("s_c4_id_pc", id_pc, 32'h3008);
    check("s_c4_instr", id_instr, 32'h2000_3008);

    // Backpressure: two entries fill the FIFO, then the PC holds.
    restart();
    drive(1, 0, 0, 0);
    check("bp_b0_req", {31'b0, imem_req}, 32'd1);
    drive(1, 1, 0, 0);
    check("bp_b1_req", {31'b0, imem_req}, 32'd1);
    drive(1, 1, 0, 0);
    check("bp_b2_req", {31'b0, imem_req}, 32'd0);
    check("bp_b2_pc_en", {31'b0, pc_en}, 32'd0);
    check("bp_b2_id_pc", id_pc, 32'h3000);
    drive(1, 0, 0, 0);
    check("bp_b3_req", {31'b0, imem_req}, 32'd0);
    check("bp_b3_pc_en", {31'b0, pc_en}, 32'd0);
    check("bp_b3_addr", imem_addr, 32'h3008);
    drive(1, 0, 1, 0);
    check("bp_b4_req", {31'b0, imem_req}, 32'd1);
    check("bp_b4_pc_en", {31'b0, pc_en}, 32'd1);
    check("bp_b4_id_pc", id_pc, 32'h3000);
    drive(1, 1, 1, 0);
    check("bp_b5_id_pc", id_pc, 32'h3004);
    drive(0, 0, 1, 0);
    check("bp_b6_id_pc", id_pc, 32'h3008);
    check("bp_b6_instr", id_instr, 32'h2000_3008);
    drive(0, 0, 1, 0);
    check("bp_b7_valid", {31'b0, id_valid}, 32'd0);

    // Slow memory: gnt after 3 cycles, rvalid 4 cycles after gnt.
    restart();
    drive(0, 0, 1, 0);
    check("sl_s0_req", {31'b0, imem_req}, 32'd1);
    check("sl_s0_pc_en", {31'b0, pc_en}, 32'd0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    check("sl_s2_pc_en", {31'b0, pc_en}, 32'd0);
    drive(1, 0, 1, 0);
    check("sl_s3_pc_en", {31'b0, pc_en}, 32'd1);
    drive(0, 0, 1, 0);
    check("sl_s4_req", {31'b0, imem_req}, 32'd0);
    check("sl_s4_pc_en", {31'b0, pc_en}, 32'd0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);
    check("sl_s7_pc_en", {31'b0, pc_en}, 32'd0);
    check("sl_s7_valid", {31'b0, id_valid}, 32'd0);
    drive(0, 0, 1, 0);
    check("sl_s8_valid", {31'b0, id_valid}, 32'd1);
    check("sl_s8_id_pc", id_pc, 32'h3000);
    check("sl_s8_instr", id_instr, 32'h2000_3000);
    drive(0, 0, 1, 0);
    check("sl_s9_valid", {31'b0, id_valid}, 32'd0);

    // Redirect while 0x3008 is outstanding; its response is dropped.
    restart();
    drive(1, 0, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0);
    check("rw_r2_id_pc", id_pc, 32'h3000);
    drive(0, 0, 1, 1);
    check("rw_r3_pc_en", {31'b0, pc_en}, 32'd1);
    check("rw_r3_req", {31'b0, imem_req}, 32'd0);
    drive(0, 0, 1, 0);
    check("rw_r4_valid", {31'b0, id_valid}, 32'd0);
    check("rw_r4_req", {31'b0, imem_req}, 32'd0);
    drive(0, 1, 1, 0);
    check("rw_r5_req", {31'b0, imem_req}, 32'd0);
    drive(1, 0, 1, 0);
    check("rw_r6_valid", {31'b0, id_valid}, 32'd0);
    check("rw_r6_req", {31'b0, imem_req}, 32'd1);
    check("rw_r6_addr", imem_addr, 32'h4000);
    drive(1, 1, 1, 0);
    drive(0, 0, 1, 0);
    check("rw_r8_valid", {31'b0, id_valid}, 32'd1);
    check("rw_r8_id_pc", id_pc, 32'h4000);
    check("rw_r8_instr", id_instr, 32'h2000_4000);

    // Redirect coincident with rvalid and pop.
    restart();
    drive(1, 0, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 1);
    check("rc_t2_valid", {31'b0, id_valid}, 32'd1);
    check("rc_t2_req", {31'b0, imem_req}, 32'd0);
    check("rc_t2_pc_en", {31'b0, pc_en}, 32'd1);
    drive(0, 0, 1, 0);
    check("rc_t3_valid", {31'b0, id_valid}, 32'd0);
    check("rc_t3_req", {31'b0, imem_req}, 32'd1);
    check("rc_t3_addr", imem_addr, 32'h4000);
    drive(0, 0, 1, 0);
    check("rc_t4_valid", {31'b0, id_valid}, 32'd0);

    // Asynchronous reset between edges while a request is in WAIT.
    restart();
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    check("ar_pre_valid", {31'b0, id_valid}, 32'd1);
    check("ar_pre_req", {31'b0, imem_req}, 32'd1);
    check("ar_pre_pc_en", {31'b0, pc_en}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, id_valid}, 32'd0);
    check("ar_req", {31'b0, imem_req}, 32'd0);
    check("ar_pc_en", {31'b0, pc_en}, 32'd0);
    check("ar_addr", imem_addr, 32'd0);
    check("ar_id_pc", id_pc, 32'h3000);
    @(negedge clk);
    Reset_n     = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    id_ready    = 1'b0;
    #1;
    drive(0, 0, 0, 0);
    check("ar_stray_valid", {31'b0, id_valid}, 32'd0);
    check("ar_stray_instr", id_instr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller between the PC register and instruction memory. It issues the current PC as a fetch request, tracks one outstanding request, and buffers returned instructions with their PCs in a small FIFO feeding the IF/ID stage. It drives the PC register's Enable, so the PC advances only when a request is accepted or a redirect loads a new target. It also discards in-flight fetches on a branch or jump redirect.

## Interface

- DEPTH, 2: instruction FIFO entries; power of two, ≥2
- RESET_PC, 32'h00003000: value driven on id_pc at reset
- clk  in  1  clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- pc  in  32  current PC from PC register
- pc_en  out  1  Enable to PC register
- redirect  in  1  branch/jump taken; PC register loads target this edge
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- id_valid  out  1  FIFO head valid
- id_instr  out  32  FIFO head instruction
- id_pc  out  32  FIFO head PC
- id_ready  in  1  decode consumes head this cycle

## Operation

- States: IDLE (no outstanding request), WAIT (one accepted, awaiting rvalid), DROP (outstanding response to discard).
- The block has at most one outstanding request.
- Occupancy: occ = count + (state==WAIT).
- Pop: pop = id_valid & id_ready & !redirect.
- Issue condition: (IDLE, or WAIT with imem_rvalid) and !redirect and (occ - pop) < DEPTH.
- imem_req equals the issue condition.
- imem_addr = pc.
- accept = imem_req & imem_gnt.
- pc_en = accept | redirect.
- On accept: latch pc into req_pc and go to WAIT. WAIT+rvalid+accept stays in WAIT.
- WAIT with imem_rvalid and no redirect: push {req_pc, imem_rdata}. Go to IDLE unless a new request is accepted the same cycle.
- Push and pop may occur in the same cycle; count is unchanged.
- Push never overflows because the occupancy check reserves a slot.
- Redirect:
  - Clears the FIFO: count, read and write pointers go to 0. id_valid is 0 next cycle.
  - No request is issued that cycle.
  - WAIT without rvalid goes to DROP.
  - WAIT with rvalid discards the data and goes to IDLE.
  - DROP stays DROP.
  - IDLE stays IDLE.
  - Redirect has priority over pop and push.
- DROP: imem_req = 0. On imem_rvalid, discard the data and go to IDLE. A redirect in the same cycle also lands in IDLE.
- imem_rvalid in IDLE is ignored.
- imem_gnt without imem_req is ignored.

## Timing

- Reset (Reset_n low, asynchronous):
  - state = IDLE, count = 0, pointers = 0.
  - id_valid = 0, id_instr = 0, id_pc = RESET_PC.
  - imem_req, pc_en and imem_addr are combinational but forced to 0 while Reset_n is low.
- Reset mid-operation abandons any outstanding request. A later rvalid lands in IDLE and is ignored.
- imem_req, imem_addr and pc_en are combinational from state, count, pc, id_ready, redirect, imem_gnt and imem_rvalid.
- The memory asserts rvalid no earlier than the cycle after gnt.
- id_valid, id_instr and id_pc come from registered FIFO storage.
- Latency: request accepted at edge N, rvalid in cycle N+1, id_valid high in cycle N+2.
- With a 1-cycle memory and id_ready held high, throughput is one instruction per cycle.
- When the FIFO is full with no pop, imem_req = 0 and pc_en = 0, so the PC holds.

## Test plan

- Reset then stream: Reset_n released, pc = 0x3000; memory gnt=1, rvalid one cycle later with data = 0x20000000|addr; id_ready=1. Required response:
  - id_valid rises 2 cycles after the first request.
  - id_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - pc_en is high every cycle.
- Backpressure: id_ready=0 with DEPTH=2. Required response:
  - Exactly 2 entries are pushed, then imem_req=0 and pc_en=0.
  - After id_ready=1, one pop frees a slot and imem_req reasserts in that same cycle.
- Slow memory: gnt delayed 3 cycles, rvalid 4 cycles after gnt. Required response:
  - pc_en is high only in the gnt cycle.
  - The instruction appears with id_pc equal to the PC at acceptance.
- Redirect in WAIT: request at 0x3008 outstanding, redirect pulsed, rvalid arrives 2 cycles later. Required response:
  - FIFO is empty next cycle and pc_en=1 in the redirect cycle.
  - The 0x3008 data is never presented on id_*.
  - The next request issues from the new pc after rvalid.
- Redirect coincident with rvalid and pop: the response is dropped, the FIFO is cleared, state goes to IDLE, and no request is issued that cycle.
- Asynchronous reset asserted mid-WAIT between clock edges: id_valid=0 and imem_req=0 immediately. A subsequent stray rvalid produces no FIFO entry.
